pc_sequencer: RTL

- Next-PC controller for the 8-bit microprocessor. Owns the program counter register and the fetch/execute sequencing.
- Implements sequential increment, jump, conditional branch, call/return (hardware return-address stack) and halt.
- Sits between the instruction decoder, which supplies op/target/condition, and instruction memory, which is addressed by output_PC.

---
 rtl/pc_sequencer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Next-PC controller for the 8-bit microprocessor.
//
//                This block owns the program counter and sequences each
//                instruction through two phases:
//                  - FETCH: instruction memory reads output_PC.
//                  - EXEC : the decoder's op is accepted and the next PC is
//                           chosen.
//                The next PC can come from the incrementer, a jump, a
//                conditional branch, a call or a return. Calls and returns
//                use a small hardware return-address stack. HALT freezes
//                the block until reset.
//
//  Ports       : input_Clock      - rising-edge clock
//                input_Reset      - synchronous active-high reset
//                input_Stall      - hold all state this cycle
//                input_Op_Valid   - decoder op valid (used in EXEC only)
//                input_Op         - 0 NEXT,1 JUMP,2 BRANCH,3 CALL,4 RET,
//                                   5 HALT, 6/7 behave as NEXT
//                input_Cond       - branch condition, used by BRANCH only
//                input_Target     - jump/branch/call destination
//                output_PC        - registered program counter
//                output_Fetch     - high in FETCH (memory read of PC)
//                output_Halted    - high in HALT
//                output_Stack_Err - sticky call-overflow / ret-underflow
//                output_State     - 00 FETCH, 01 EXEC, 10 HALT
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  input_Clock,
    input  logic                  input_Reset,
    input  logic                  input_Stall,
    input  logic                  input_Op_Valid,
    input  logic [2:0]            input_Op,
    input  logic                  input_Cond,
    input  logic [ADDR_WIDTH-1:0] input_Target,
    output logic [ADDR_WIDTH-1:0] output_PC,
    output logic                  output_Fetch,
    output logic                  output_Halted,
    output logic                  output_Stack_Err,
    output logic [1:0]            output_State
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // The pointer indexes the stack entries. The count needs one extra
    // bit so that it can represent the "full" value STACK_DEPTH.
    localparam int c_PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(STACK_DEPTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(STACK_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_FETCH  = 2'b00;
    localparam logic [1:0] c_ST_EXEC   = 2'b01;
    localparam logic [1:0] c_ST_HALT   = 2'b10;

    localparam logic [2:0] c_OP_NEXT   = 3'd0;
    localparam logic [2:0] c_OP_JUMP   = 3'd1;
    localparam logic [2:0] c_OP_BRANCH = 3'd2;
    localparam logic [2:0] c_OP_CALL   = 3'd3;
    localparam logic [2:0] c_OP_RET    = 3'd4;
    localparam logic [2:0] c_OP_HALT   = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [c_CNT_W-1:0]    w_count_next;
    logic                  w_err_next;
    logic                  w_push;

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [c_PTR_W-1:0]    w_wr_ptr;
    logic [c_PTR_W-1:0]    w_top_ptr;
    logic [ADDR_WIDTH-1:0] w_top;

    // The incrementer wraps naturally at 2^ADDR_WIDTH.
    assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);

    // The stack grows upward. The next free slot equals the count, and the
    // top of stack is the entry just below it. When the count is zero,
    // w_top is a don't-care because RET takes the underflow path instead.
    assign w_wr_ptr  = r_count[c_PTR_W-1:0];
    assign w_top_ptr = c_PTR_W'(r_count - c_CNT_ONE);
    assign w_top     = r_stack[w_top_ptr];

    // An op is consumed only in EXEC, with valid asserted and no stall.
    // Stall therefore wins over Op_Valid.
    assign w_accept  = (r_state == c_ST_EXEC) && !input_Stall && input_Op_Valid;

    // ------------------------------------------------------------------
    // Next-state / next-PC logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_count_next = r_count;
        w_err_next   = r_err;
        w_push       = 1'b0;

        case (r_state)
            c_ST_FETCH: begin
                if (!input_Stall) begin
                    w_state_next = c_ST_EXEC;
                end
            end

            c_ST_EXEC: begin
                if (w_accept) begin
                    w_state_next = c_ST_FETCH;
                    case (input_Op)
                        c_OP_NEXT: begin
                            w_pc_next = w_pc_inc;
                        end
                        c_OP_JUMP: begin
                            w_pc_next = input_Target;
                        end
                        c_OP_BRANCH: begin
                            w_pc_next = input_Cond ? input_Target : w_pc_inc;
                        end
                        c_OP_CALL: begin
                            // On overflow the existing entries are kept.
                            // The jump is still taken.
                            w_pc_next = input_Target;
                            if (r_count == c_CNT_FULL) begin
                                w_err_next = 1'b1;
                            end else begin
                                w_push       = 1'b1;
                                w_count_next = r_count + c_CNT_ONE;
                            end
                        end
                        c_OP_RET: begin
                            // On underflow, execution falls through to the
                            // next sequential instruction.
                            if (r_count == '0) begin
                                w_pc_next  = w_pc_inc;
                                w_err_next = 1'b1;
                            end else begin
                                w_pc_next    = w_top;
                                w_count_next = r_count - c_CNT_ONE;
                            end
                        end
                        c_OP_HALT: begin
                            w_state_next = c_ST_HALT;
                        end
                        default: begin
                            // Reserved opcodes 6 and 7 behave as NEXT.
                            w_pc_next = w_pc_inc;
                        end
                    endcase
                end
            end

            c_ST_HALT: begin
                // Frozen. Only reset leaves this state.
            end

            default: begin
                // Encoding 11 is unreachable; recover to FETCH if it is
                // ever entered.
                w_state_next = c_ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge input_Clock) begin
        if (input_Reset) begin
            r_state <= c_ST_FETCH;
            r_pc    <= RESET_VECTOR;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_count <= w_count_next;
            r_err   <= w_err_next;
        end
    end

    // Return-address storage. The return address written is always PC+1
    // of the CALL instruction.
    always_ff @(posedge input_Clock) begin
        if (input_Reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (w_push) begin
            r_stack[w_wr_ptr] <= w_pc_inc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state only
    // ------------------------------------------------------------------
    assign output_PC        = r_pc;
    assign output_State     = r_state;
    assign output_Fetch     = (r_state == c_ST_FETCH);
    assign output_Halted    = (r_state == c_ST_HALT);
    assign output_Stack_Err = r_err;

endmodule
`default_nettype wire
